// File: rtl/zero_cross_period_meter_if.sv
// Sample stream in, averaged period result out.
interface zero_cross_period_meter_if;
   logic signed [15:0] sample_in;
   logic               sample_valid;
   logic signed [16:0] period_out;
   logic               period_valid;
   logic               no_signal;

   modport master (
      output sample_in, sample_valid,
      input  period_out, period_valid, no_signal
   );

   modport slave (
      input  sample_in, sample_valid,
      output period_out, period_valid, no_signal
   );
endinterface

// File: rtl/zero_cross_period_meter.sv
// Rising zero-crossing period meter with Schmitt hysteresis, glitch rejection,
// timeout-based loss-of-signal detection and power-of-two averaging.
module zero_cross_period_meter #(
   parameter int HYST       = 64,
   parameter int MIN_PERIOD = 8,
   parameter int MAX_PERIOD = 4095,
   parameter int AVG_LOG2   = 2
) (
   input  logic clk,
   input  logic reset,
   zero_cross_period_meter_if.slave bus
);
   localparam int ACC_W  = 16 + AVG_LOG2;
   localparam int NACC_W = AVG_LOG2 + 1;
   localparam logic [NACC_W-1:0] AVG_N    = NACC_W'(1 << AVG_LOG2);
   localparam logic signed [16:0] HYST_POS = 17'(HYST);
   localparam logic signed [16:0] HYST_NEG = -HYST_POS;

   typedef enum logic {IDLE, TRACK} state_t;

   state_t              state_reg, state_next;
   logic                hi_reg, hi_next;
   logic [15:0]         cnt_reg, cnt_next;
   logic [ACC_W-1:0]    acc_reg, acc_next;
   logic [NACC_W-1:0]   nacc_reg, nacc_next;
   logic [16:0]         period_reg, period_next;
   logic                valid_reg, valid_next;
   logic                no_signal_reg, no_signal_next;

   logic signed [16:0]  s_ext;
   logic                rise;
   logic [16:0]         p;
   logic [ACC_W-1:0]    acc_sum;
   logic [NACC_W-1:0]   nacc_inc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         hi_reg        <= 1'b0;
         cnt_reg       <= '0;
         acc_reg       <= '0;
         nacc_reg      <= '0;
         period_reg    <= '0;
         valid_reg     <= 1'b0;
         no_signal_reg <= 1'b1;
      end else begin
         state_reg     <= state_next;
         hi_reg        <= hi_next;
         cnt_reg       <= cnt_next;
         acc_reg       <= acc_next;
         nacc_reg      <= nacc_next;
         period_reg    <= period_next;
         valid_reg     <= valid_next;
         no_signal_reg <= no_signal_next;
      end
   end

   // Sign-extend by one bit so the threshold compares can never wrap.
   always_comb begin
      s_ext    = {bus.sample_in[15], bus.sample_in};
      rise     = bus.sample_valid && !hi_reg && (s_ext >= HYST_POS);
      p        = {1'b0, cnt_reg} + 17'd1;
      acc_sum  = acc_reg + ACC_W'(p);
      nacc_inc = nacc_reg + NACC_W'(1);
   end

   always_comb begin
      state_next     = state_reg;
      hi_next        = hi_reg;
      cnt_next       = cnt_reg;
      acc_next       = acc_reg;
      nacc_next      = nacc_reg;
      period_next    = period_reg;
      valid_next     = 1'b0;
      no_signal_next = no_signal_reg;

      if (bus.sample_valid) begin
         if (!hi_reg && (s_ext >= HYST_POS)) begin
            hi_next = 1'b1;
         end else if (hi_reg && (s_ext <= HYST_NEG)) begin
            hi_next = 1'b0;
         end

         case (state_reg)
            IDLE: begin
               cnt_next = '0;
               if (rise) begin
                  state_next = TRACK;
               end
            end
            TRACK: begin
               if (p > 17'(MAX_PERIOD)) begin
                  // A rising event on the timeout sample re-arms immediately.
                  state_next     = rise ? TRACK : IDLE;
                  cnt_next       = '0;
                  acc_next       = '0;
                  nacc_next      = '0;
                  no_signal_next = 1'b1;
               end else if (rise && (p < 17'(MIN_PERIOD))) begin
                  cnt_next = p[15:0];
               end else if (rise) begin
                  cnt_next = '0;
                  if (nacc_inc == AVG_N) begin
                     period_next    = {1'b0, acc_sum[ACC_W-1:AVG_LOG2]};
                     valid_next     = 1'b1;
                     acc_next       = '0;
                     nacc_next      = '0;
                     no_signal_next = 1'b0;
                  end else begin
                     acc_next  = acc_sum;
                     nacc_next = nacc_inc;
                  end
               end else begin
                  cnt_next = p[15:0];
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.period_out   = period_reg;
      bus.period_valid = valid_reg;
      bus.no_signal    = no_signal_reg;
   end
endmodule

// File: tb/tb_zero_cross_period_meter.sv
// Vector table of square-wave periods plus hand-written corner sequences;
// expected averages are queued when the completing edge is driven.
module tb_zero_cross_period_meter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   zero_cross_period_meter_if bus ();

   zero_cross_period_meter #(
      .HYST(64), .MIN_PERIOD(8), .MAX_PERIOD(4095), .AVG_LOG2(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      int p0, p1, p2, p3;
      int stride;
      int amp;
      bit glitch;
      int exp;
   } vec_t;

   vec_t vecs[8];
   int   pers[16];
   int   exp_q[$];
   int   pulse_cyc[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   pulse_cnt = 0;
   int   mon_exp;
   int   base;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (bus.period_valid === 1'b1) begin
         pulse_cnt++;
         pulse_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: got period_out %0d, required no pulse",
                     int'(bus.period_out));
         end else begin
            mon_exp = exp_q.pop_front();
            check("period_out", int'(bus.period_out), mon_exp);
            check("no_signal_at_pulse", int'(bus.no_signal), 0);
         end
         $display("[TB] pulse at cycle %0d period_out=%0d", cyc, int'(bus.period_out));
      end
   end

   task automatic drive_sample(input int v, input int stride);
      bus.sample_in    = 16'(v);
      bus.sample_valid = 1'b1;
      @(negedge clk);
      bus.sample_valid = 1'b0;
      repeat (stride - 1) @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      reset            = 1'b1;
      bus.sample_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check({tag, "_rst_period_out"}, int'(bus.period_out), 0);
      check({tag, "_rst_period_valid"}, int'(bus.period_valid), 0);
      check({tag, "_rst_no_signal"}, int'(bus.no_signal), 1);
   endtask

   // Low prelude, then n periods from pers[] (low-to-high edge at each start),
   // then one closing rising edge. Edge k completes an average when k = 5, 9, ...
   task automatic run_periods(input int n, input int stride, input int amp,
                              input bit glitch, input bit push_en, input int exp);
      int h;
      int v;
      repeat (3) drive_sample(-amp, stride);
      for (int e = 0; e < n; e++) begin
         h = pers[e] / 2;
         if (push_en && (e + 1) >= 5 && (e % 4) == 0) exp_q.push_back(exp);
         for (int i = 0; i < pers[e]; i++) begin
            v = (i < h) ? amp : -amp;
            // Dip and re-rise right after an accepted edge: a too-short period.
            if (glitch && e == 1 && (i == 1 || i == 2)) v = -amp;
            drive_sample(v, stride);
         end
      end
      if (push_en && (n + 1) >= 5 && (n % 4) == 0) exp_q.push_back(exp);
      drive_sample(amp, stride);
   endtask

   initial begin
      reset            = 1'b1;
      bus.sample_in    = '0;
      bus.sample_valid = 1'b0;
      repeat (2) @(negedge clk);

      vecs[0] = '{20, 20, 20, 20, 1, 1000, 1'b0, 20};
      vecs[1] = '{19, 20, 21, 20, 1, 1000, 1'b0, 20};
      vecs[2] = '{21, 21, 21, 22, 1, 1000, 1'b0, 21};
      vecs[3] = '{20, 20, 20, 20, 3, 1000, 1'b0, 20};
      vecs[4] = '{40, 40, 40, 40, 1, 1000, 1'b1, 40};
      vecs[5] = '{8, 8, 8, 8, 1, 1000, 1'b0, 8};
      vecs[6] = '{4095, 4095, 4095, 4095, 1, 1000, 1'b0, 4095};
      vecs[7] = '{20, 20, 20, 20, 1, 64, 1'b0, 20};

      for (int t = 0; t < 8; t++) begin
         do_reset($sformatf("v%0d", t));
         pers[0] = vecs[t].p0;
         pers[1] = vecs[t].p1;
         pers[2] = vecs[t].p2;
         pers[3] = vecs[t].p3;
         base = pulse_cnt;
         run_periods(4, vecs[t].stride, vecs[t].amp, vecs[t].glitch, 1'b1, vecs[t].exp);
         @(negedge clk);
         check($sformatf("v%0d_pending", t), exp_q.size(), 0);
         check($sformatf("v%0d_pulses", t), pulse_cnt - base, 1);
         $display("[TB] vector %0d periods %0d/%0d/%0d/%0d stride %0d expect %0d",
                  t, vecs[t].p0, vecs[t].p1, vecs[t].p2, vecs[t].p3,
                  vecs[t].stride, vecs[t].exp);
      end

      // Continuous wave, valid every 3rd cycle: two averages, 240 clocks apart.
      do_reset("stride3");
      for (int i = 0; i < 8; i++) pers[i] = 20;
      base = pulse_cnt;
      run_periods(8, 3, 1000, 1'b0, 1'b1, 20);
      @(negedge clk);
      check("stride3_pulses", pulse_cnt - base, 2);
      check("stride3_spacing",
            pulse_cyc[pulse_cyc.size() - 1] - pulse_cyc[pulse_cyc.size() - 2], 240);
      $display("[TB] stride-3 continuous wave done");

      // Sub-threshold noise never produces an event.
      do_reset("noise");
      base = pulse_cnt;
      repeat (200) drive_sample(int'($urandom_range(0, 100)) - 50, 1);
      check("noise_no_signal", int'(bus.no_signal), 1);
      check("noise_pulses", pulse_cnt - base, 0);
      $display("[TB] noise sequence done");

      // Amplitude one LSB below the threshold never crosses.
      do_reset("amp63");
      for (int i = 0; i < 4; i++) pers[i] = 20;
      base = pulse_cnt;
      run_periods(4, 1, 63, 1'b0, 1'b0, 0);
      @(negedge clk);
      check("amp63_no_signal", int'(bus.no_signal), 1);
      check("amp63_pulses", pulse_cnt - base, 0);
      $display("[TB] sub-hysteresis wave done");

      // Lock, then silence: timeout on the 4096th sample after the last event.
      do_reset("tmo");
      for (int i = 0; i < 4; i++) pers[i] = 20;
      base = pulse_cnt;
      run_periods(4, 1, 1000, 1'b0, 1'b1, 20);
      @(negedge clk);
      check("tmo_lock_pulses", pulse_cnt - base, 1);
      for (int j = 1; j <= 4095; j++) drive_sample(0, 1);
      check("tmo_no_signal_before", int'(bus.no_signal), 0);
      drive_sample(0, 1);
      check("tmo_no_signal_after", int'(bus.no_signal), 1);
      check("tmo_period_hold", int'(bus.period_out), 20);
      base = pulse_cnt;
      run_periods(4, 1, 1000, 1'b0, 1'b1, 20);
      @(negedge clk);
      check("tmo_relock_pulses", pulse_cnt - base, 1);
      check("tmo_relock_pending", exp_q.size(), 0);
      $display("[TB] timeout and relock done");

      // Reset with three periods accumulated discards the partial average.
      do_reset("mid");
      base = pulse_cnt;
      run_periods(4, 1, 1000, 1'b0, 1'b1, 20);
      run_periods(3, 1, 1000, 1'b0, 1'b0, 0);
      @(negedge clk);
      check("mid_partial_pulses", pulse_cnt - base, 1);
      do_reset("mid2");
      base = pulse_cnt;
      run_periods(4, 1, 1000, 1'b0, 1'b1, 20);
      @(negedge clk);
      check("mid_fresh_pulses", pulse_cnt - base, 1);
      check("mid_pending", exp_q.size(), 0);
      $display("[TB] mid-measurement reset done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
